// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
// Front end of the five-stage pipeline: owns the fetch PC, presents it to the
// combinational instruction memory and captures the returned word together
// with its PC+4 into the IF/ID register. Honours stall from hazard detection
// and redirect/flush from branch resolution.
//
// Optional feature macro: IFETCH_FAULT_CHECK_EN
//   defined   -> misaligned redirects and out-of-range fetches raise a sticky
//                FetchFault and park the stage in HALT until reset.
//   undefined -> FetchFault is constant 0, misaligned redirect bits are
//                cleared and out-of-range fetches proceed normally.

module instruction_fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 128,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        RedirectEn,
    input  logic [31:0] RedirectPC,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        FetchFault
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_e;

    // One past the last valid byte address; 33 bits so the product cannot wrap.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcplus4_q, pcplus4_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;

    logic [31:0]  pc_plus4_s;
    logic         redirect_misaligned_s;
    logic         pc_out_of_range_s;

    assign pc_plus4_s            = pc_q + 32'd4;
    assign redirect_misaligned_s = RedirectEn & (RedirectPC[1:0] != 2'b00);
    assign pc_out_of_range_s     = ({1'b0, pc_q} >= IMEM_BYTES);

    assign ImemAddress   = {pc_q[31:2], 2'b00};
    assign PC            = pc_q;
    assign IF_ID_Instr   = instr_q;
    assign IF_ID_PCPlus4 = pcplus4_q;
    assign IF_ID_Valid   = valid_q;
    assign FetchFault    = fault_q;

    // Next-state logic: sequencing, PC update and IF/ID capture/squash.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
`ifdef IFETCH_FAULT_CHECK_EN
        fault_d   = fault_q;
`else
        // fault_q never leaves zero in this build, so this term folds to 0.
        fault_d   = fault_q & (redirect_misaligned_s | pc_out_of_range_s);
`endif

        case (state_q)
            ST_BOOT: begin
                // Single settling cycle: nothing captured, PC held.
                state_d = ST_RUN;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end

            ST_RUN: begin
                if (RedirectEn) begin
`ifdef IFETCH_FAULT_CHECK_EN
                    if (redirect_misaligned_s) begin
                        // Misaligned target: freeze PC and park in HALT.
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = {RedirectPC[31:2], 2'b00};
                    end
`else
                    pc_d = {RedirectPC[31:2], 2'b00};
`endif
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (Stall) begin
                    // Hold PC and IF/ID; only a flush may squash the latch.
                    if (Flush) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = instr_q;
                    end
                end else begin
`ifdef IFETCH_FAULT_CHECK_EN
                    if (pc_out_of_range_s) begin
                        // Do not capture the word from outside the memory.
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        pc_d      = pc_plus4_s;
                        instr_d   = ImemInstruction;
                        pcplus4_d = pc_plus4_s;
                        valid_d   = 1'b1;
                    end
`else
                    pc_d      = pc_plus4_s;
                    instr_d   = ImemInstruction;
                    pcplus4_d = pc_plus4_s;
                    valid_d   = 1'b1;
`endif
                    if (Flush) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        valid_d = valid_d;
                    end
                end
            end

            ST_HALT: begin
                // Frozen until reset; IF/ID presents a bubble.
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_BOOT;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset taking priority.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= PC_RESET;
            instr_q   <= NOP_WORD;
            pcplus4_q <= 32'h0000_0000;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

endmodule
